spi_slave_port: RTL and testbench

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

---
 rtl/spi_slave_pkg.sv | 30 +++
 rtl/spi_slave_sync.sv | 38 +++
 rtl/spi_slave_port.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave_port.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_pkg                                                        |
// | Register map, status/control bit positions and SPI data width.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_slave_pkg;

  localparam int c_DATA_W = 8;

  typedef enum logic [2:0] {
    REG_RXDATA  = 3'd0,
    REG_TXDATA  = 3'd1,
    REG_STATUS  = 3'd2,
    REG_CONTROL = 3'd3,
    REG_EOPVAL  = 3'd6
  } spi_reg_e;

  // Control register enables share these positions with the status flags.
  localparam int c_ST_EOP  = 9;
  localparam int c_ST_E    = 8;
  localparam int c_ST_RRDY = 7;
  localparam int c_ST_TRDY = 6;
  localparam int c_ST_TMT  = 5;
  localparam int c_ST_TOE  = 4;
  localparam int c_ST_ROE  = 3;
  localparam int c_ST_TUR  = 2;

endpackage
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_sync                                                       |
// | Multi-flop synchronizer with single-cycle rise/fall pulses.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_slave_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to the bus idle level so releasing reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];
  assign rise     = sync_out & ~r_prev;
  assign fall     = ~sync_out & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_port                                                       |
// | SPI mode-0 slave with CPU register port. Define SPI_SLAVE_EOP_EN to  |
// | enable end-of-packet detection against the EOP value register.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  output logic        endofpacket
);

  logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
  logic w_ss_sync, w_ss_rise, w_ss_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .async_in(SCLK),
    .sync_out(w_sclk_level_unused), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .async_in(SS_n),
    .sync_out(w_ss_sync), .rise(w_ss_rise), .fall(w_ss_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // CPU access strobes: first cycle of a request, the following cycle ignored.
  logic w_rd_strobe, w_wr_strobe, r_rd_strobe_d, r_wr_strobe_d;
  assign w_rd_strobe = spi_select & ~read_n & ~r_rd_strobe_d;
  assign w_wr_strobe = spi_select & ~write_n & ~r_wr_strobe_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_strobe_d <= 1'b0;
      r_wr_strobe_d <= 1'b0;
    end else begin
      r_rd_strobe_d <= w_rd_strobe;
      r_wr_strobe_d <= w_wr_strobe;
    end
  end

  logic w_rx_read, w_tx_write, w_tx_accept, w_status_write, w_ctrl_write;
  assign w_rx_read      = w_rd_strobe & (mem_addr == REG_RXDATA);
  assign w_tx_write     = w_wr_strobe & (mem_addr == REG_TXDATA);
  assign w_status_write = w_wr_strobe & (mem_addr == REG_STATUS);
  assign w_ctrl_write   = w_wr_strobe & (mem_addr == REG_CONTROL);

  // Serial engine
  logic [c_DATA_W-1:0] r_shift, r_rx_holding, r_tx_holding;
  logic [c_DATA_W-1:0] w_rx_byte, w_load_byte;
  logic [2:0]          r_bit_cnt;
  logic                r_tx_primed, r_miso;
  logic                w_active, w_bit_rise, w_byte_done, w_load;

  assign w_active    = ~w_ss_sync;
  assign w_bit_rise  = w_sclk_rise & w_active;
  assign w_byte_done = w_bit_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_shift[c_DATA_W-2:0], w_mosi};
  assign w_load      = w_ss_fall | w_byte_done;
  assign w_load_byte = r_tx_primed ? r_tx_holding : '0;
  assign w_tx_accept = w_tx_write & ~r_tx_primed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= 3'd0;
      r_miso       <= 1'b0;
      r_rx_holding <= '0;
    end else if (w_ss_rise) begin
      r_bit_cnt <= 3'd0;
    end else if (w_ss_fall) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= w_load_byte;
      r_miso    <= w_load_byte[c_DATA_W-1];
    end else if (w_bit_rise) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_byte_done) begin
        r_rx_holding <= w_rx_byte;
        r_shift      <= w_load_byte;
      end else begin
        r_shift <= w_rx_byte;
      end
    end else if (w_sclk_fall && w_active) begin
      r_miso <= r_shift[c_DATA_W-1];
    end
  end

  // Transmit holding register; a shift-register load consumes the primed byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_holding <= '0;
      r_tx_primed  <= 1'b0;
    end else begin
      if (w_tx_accept) r_tx_holding <= data_from_cpu[c_DATA_W-1:0];
      r_tx_primed <= w_tx_accept | (r_tx_primed & ~w_load);
    end
  end

  // Status flags: hardware set beats CPU clear in the same cycle.
  logic r_rrdy, r_roe, r_toe, r_tur;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rrdy <= 1'b0;
      r_roe  <= 1'b0;
      r_toe  <= 1'b0;
      r_tur  <= 1'b0;
    end else begin
      r_rrdy <= w_byte_done | (r_rrdy & ~w_rx_read);
      r_roe  <= (w_byte_done & r_rrdy & ~w_rx_read) | (r_roe & ~w_status_write);
      r_toe  <= (w_tx_write & r_tx_primed) | (r_toe & ~w_status_write);
      r_tur  <= (w_load & ~r_tx_primed) | (r_tur & ~w_status_write);
    end
  end

  logic        w_eop;
  logic [15:0] w_eop_value_rd;
`ifdef SPI_SLAVE_EOP_EN
  logic [15:0] r_eop_value;
  logic        r_eop, w_eop_set;
  assign w_eop_set = (w_byte_done & (w_rx_byte == r_eop_value[c_DATA_W-1:0])) |
                     (w_tx_accept & (data_from_cpu[c_DATA_W-1:0] == r_eop_value[c_DATA_W-1:0]));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_eop_value <= '0;
      r_eop       <= 1'b0;
    end else begin
      if (w_wr_strobe && (mem_addr == REG_EOPVAL)) r_eop_value <= data_from_cpu;
      r_eop <= w_eop_set | (r_eop & ~w_status_write);
    end
  end
  assign w_eop          = r_eop;
  assign w_eop_value_rd = r_eop_value;
`else
  assign w_eop          = 1'b0;
  assign w_eop_value_rd = '0;
`endif

  logic [c_ST_EOP:c_ST_TUR] r_ctrl;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_ctrl <= '0;
    else if (w_ctrl_write) r_ctrl <= data_from_cpu[c_ST_EOP:c_ST_TUR];
  end

  logic [15:0] w_status, w_ctrl_word, w_rd_data;
  always_comb begin
    w_status            = '0;
    w_status[c_ST_EOP]  = w_eop;
    w_status[c_ST_E]    = r_roe | r_toe | r_tur;
    w_status[c_ST_RRDY] = r_rrdy;
    w_status[c_ST_TRDY] = ~r_tx_primed;
    w_status[c_ST_TMT]  = ~r_tx_primed & w_ss_sync;
    w_status[c_ST_TOE]  = r_toe;
    w_status[c_ST_ROE]  = r_roe;
    w_status[c_ST_TUR]  = r_tur;
    w_ctrl_word                    = '0;
    w_ctrl_word[c_ST_EOP:c_ST_TUR] = r_ctrl;
  end

  always_comb begin
    w_rd_data = '0;
    case (mem_addr)
      REG_RXDATA:  w_rd_data = {{(16-c_DATA_W){1'b0}}, r_rx_holding};
      REG_STATUS:  w_rd_data = w_status;
      REG_CONTROL: w_rd_data = w_ctrl_word;
      REG_EOPVAL:  w_rd_data = w_eop_value_rd;
      default:     w_rd_data = '0;
    endcase
  end

  logic [15:0] r_data_to_cpu;
  logic        r_irq;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_to_cpu <= '0;
      r_irq         <= 1'b0;
    end else begin
      if (w_rd_strobe) r_data_to_cpu <= w_rd_data;
      r_irq <= |(w_status[c_ST_EOP:c_ST_TUR] & r_ctrl);
    end
  end

  // Write-data bits that no register stores in every build.
  logic w_wdata_unused;
  assign w_wdata_unused = ^data_from_cpu[15:10];

  assign data_to_cpu   = r_data_to_cpu;
  assign irq           = r_irq;
  assign MISO          = r_miso;
  assign MISO_oe       = ~w_ss_sync;
  assign dataavailable = r_rrdy;
  assign readyfordata  = ~r_tx_primed;
  assign endofpacket   = w_eop;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_slave_port                                                    |
// | Directed register-table and SPI sequence bench for spi_slave_port.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spi_slave_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_select = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [2:0]  mem_addr = '0;
  logic [15:0] data_from_cpu = '0;
  logic [15:0] data_to_cpu;
  logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic        MISO, MISO_oe, irq, dataavailable, readyfordata, endofpacket;

`ifdef SPI_SLAVE_EOP_EN
  localparam logic [15:0] EXP_EOP_RD  = 16'h120D;
  localparam logic [15:0] EXP_EOP_BIT = 16'h0200;
`else
  localparam logic [15:0] EXP_EOP_RD  = 16'h0000;
  localparam logic [15:0] EXP_EOP_BIT = 16'h0000;
`endif

  spi_slave_port #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_select(spi_select), .read_n(read_n), .write_n(write_n),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe),
    .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata),
    .endofpacket(endofpacket)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(negedge clk);
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(negedge clk);
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1;
    d = data_to_cpu;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    cpu_read(a, d);
    check(name, d, exp);
  endtask

  // Mode-0 master at clk/8; MISO sampled just before each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = MISO;
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_set(input logic v);
    SS_n = v;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [2:0] a, logic [15:0] wd, logic [15:0] e, string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.exp = e; v.name = n;
    return v;
  endfunction

  vec_t vecs[12];
  logic [7:0] rx;

  initial begin
    vecs[0]  = mk(1'b0, 3'd2, 16'h0000, 16'h0060, "rst_status");
    vecs[1]  = mk(1'b0, 3'd0, 16'h0000, 16'h0000, "rst_rxdata");
    vecs[2]  = mk(1'b0, 3'd3, 16'h0000, 16'h0000, "rst_control");
    vecs[3]  = mk(1'b0, 3'd6, 16'h0000, 16'h0000, "rst_eopval");
    vecs[4]  = mk(1'b1, 3'd3, 16'hFFFF, 16'h0000, "wr_ctrl_all");
    vecs[5]  = mk(1'b0, 3'd3, 16'h0000, 16'h03FC, "ctrl_mask");
    vecs[6]  = mk(1'b1, 3'd3, 16'h0000, 16'h0000, "wr_ctrl_zero");
    vecs[7]  = mk(1'b0, 3'd3, 16'h0000, 16'h0000, "ctrl_zero");
    vecs[8]  = mk(1'b1, 3'd6, 16'h120D, 16'h0000, "wr_eopval");
    vecs[9]  = mk(1'b0, 3'd6, 16'h0000, EXP_EOP_RD, "eopval_rd");
    vecs[10] = mk(1'b0, 3'd5, 16'h0000, 16'h0000, "addr5_zero");
    vecs[11] = mk(1'b0, 3'd7, 16'h0000, 16'h0000, "addr7_zero");

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_miso", {15'd0, MISO}, 16'h0000);
    check("rst_miso_oe", {15'd0, MISO_oe}, 16'h0000);
    check("rst_trdy", {15'd0, readyfordata}, 16'h0001);
    check("rst_rrdy", {15'd0, dataavailable}, 16'h0000);
    check("rst_data_to_cpu", data_to_cpu, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdata);
      else            read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Loopback: tx 0xA5 out, 0x3C in
    cpu_write(3'd1, 16'h00A5);
    check("tx_trdy_low", {15'd0, readyfordata}, 16'h0000);
    read_check("tx_status", 3'd2, 16'h0000);
    ss_set(1'b0);
    check("miso_oe_active", {15'd0, MISO_oe}, 16'h0001);
    spi_bits(8'h3C, 8, rx);
    check("miso_a5", {8'd0, rx}, 16'h00A5);
    ss_set(1'b1);
    check("rrdy_set", {15'd0, dataavailable}, 16'h0001);
    read_check("lb_status", 3'd2, 16'h01E4);
    read_check("rx_3c", 3'd0, 16'h003C);
    read_check("lb_status_rd", 3'd2, 16'h0164);
    check("rrdy_clr", {15'd0, dataavailable}, 16'h0000);
    cpu_write(3'd2, 16'h0000);
    read_check("status_cleared", 3'd2, 16'h0060);

    // Underrun with TUR interrupt enabled
    cpu_write(3'd3, 16'h0004);
    check("irq_idle", {15'd0, irq}, 16'h0000);
    ss_set(1'b0);
    check("irq_tur", {15'd0, irq}, 16'h0001);
    read_check("tur_status", 3'd2, 16'h0144);
    spi_bits(8'h5A, 8, rx);
    check("miso_zero", {8'd0, rx}, 16'h0000);
    ss_set(1'b1);
    read_check("rx_5a", 3'd0, 16'h005A);
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0000);
    check("irq_cleared", {15'd0, irq}, 16'h0000);

    // Two-byte burst without reading -> overrun
    ss_set(1'b0);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    ss_set(1'b1);
    read_check("roe_status", 3'd2, 16'h01EC);
    read_check("rx_22", 3'd0, 16'h0022);
    cpu_write(3'd2, 16'h0000);

    // Second tx write while primed -> TOE, first byte kept
    cpu_write(3'd1, 16'h0077);
    cpu_write(3'd1, 16'h0099);
    read_check("toe_status", 3'd2, 16'h0110);
    ss_set(1'b0);
    spi_bits(8'h00, 8, rx);
    check("miso_77", {8'd0, rx}, 16'h0077);
    ss_set(1'b1);
    read_check("rx_00", 3'd0, 16'h0000);
    cpu_write(3'd2, 16'h0000);

    // Aborted byte after 5 bits, then a clean 0x80
    ss_set(1'b0);
    spi_bits(8'hFF, 5, rx);
    ss_set(1'b1);
    check("abort_rrdy", {15'd0, dataavailable}, 16'h0000);
    read_check("abort_status", 3'd2, 16'h0164);
    cpu_write(3'd2, 16'h0000);
    ss_set(1'b0);
    spi_bits(8'h80, 8, rx);
    ss_set(1'b1);
    read_check("rx_80", 3'd0, 16'h0080);
    cpu_write(3'd2, 16'h0000);

    // End-of-packet match on received 0x0D
    ss_set(1'b0);
    spi_bits(8'h0D, 8, rx);
    ss_set(1'b1);
    read_check("eop_status", 3'd2, 16'h01E4 | EXP_EOP_BIT);
    check("eop_pin", {15'd0, endofpacket}, {15'd0, EXP_EOP_BIT[9]});
    cpu_write(3'd2, 16'h0000);
    read_check("eop_cleared", 3'd2, 16'h00E0);
    check("eop_pin_clr", {15'd0, endofpacket}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
